branch_pred_gen: RTL and testbench

Parametrised, table-based branch predictor for the core's fetch/decode stage. It supports always-not-taken, bimodal and gshare modes. Decode looks up a prediction combinationally from the branch PC. Execute returns the resolved outcome together with the table index that was carried down the pipeline. The block also holds a global-history register, a sequenced table-clear engine and saturating lookup/mispredict statistics counters.

---
 rtl/branch_pred_gen.sv | 136 +++++++++++++
 tb/tb_branch_pred_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_gen.sv
// Table-based branch predictor (not-taken / bimodal / gshare) with global history,
// sequenced table-clear sweep and saturating lookup/mispredict counters.
module branch_pred_gen #(
    parameter int          PC_W     = 32,
    parameter int          IDX_W    = 6,
    parameter int          HIST_W   = 6,
    parameter int          MODE     = 2,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_vld,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              upd_vld,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_pred,
    input  logic              clr,
    output logic              busy,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispred
);

    // state   | meaning
    // S_IDLE  | normal predict/update operation
    // S_CLEAR | sweeping table entries back to CNT_INIT, one per cycle
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam int N_ENT = 1 << IDX_W;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic [1:0]         tbl_q [N_ENT];
    logic [1:0]         tbl_d [N_ENT];
    logic [31:0]        lk_q, lk_d;
    logic [31:0]        mp_q, mp_d;
    logic [IDX_W-1:0]   ghr_ext;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         upd_cnt;
    logic               lookup_acc;
    logic               upd_acc;
    logic               unused_pc_hi;

    assign unused_pc_hi = ^lookup_pc[PC_W-1:IDX_W];

    assign busy         = (state_q == S_CLEAR);
    assign lookup_acc   = lookup_vld && !busy;
    assign upd_acc      = upd_vld && !busy;
    assign stat_lookups = lk_q;
    assign stat_mispred = mp_q;

    always_comb begin
        ghr_ext = '0;
        ghr_ext[HIST_W-1:0] = ghr_q;
        if (MODE == 2) begin
            idx = lookup_pc[IDX_W-1:0] ^ ghr_ext;
        end else begin
            idx = lookup_pc[IDX_W-1:0];
        end
        pred_idx = idx;
        if (MODE == 0) begin
            pred_taken = 1'b0;
        end else begin
            pred_taken = lookup_acc ? tbl_q[idx][1] : 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        lk_d    = lk_q;
        mp_d    = mp_q;
        tbl_d   = tbl_q;
        upd_cnt = tbl_q[upd_idx];

        if (lookup_acc && (lk_q != 32'hFFFF_FFFF)) begin
            lk_d = lk_q + 32'd1;
        end

        if (upd_acc) begin
            ghr_d = HIST_W'({ghr_q, upd_taken});
            if ((upd_taken != upd_pred) && (mp_q != 32'hFFFF_FFFF)) begin
                mp_d = mp_q + 32'd1;
            end
            if (MODE != 0) begin
                if (upd_taken && (upd_cnt != 2'd3)) begin
                    tbl_d[upd_idx] = upd_cnt + 2'd1;
                end else if (!upd_taken && (upd_cnt != 2'd0)) begin
                    tbl_d[upd_idx] = upd_cnt - 2'd1;
                end
            end
        end

        if (state_q == S_CLEAR) begin
            tbl_d[ptr_q] = CNT_INIT;
            ptr_d        = ptr_q + IDX_W'(1);
            if (ptr_q == IDX_W'(N_ENT - 1)) begin
                state_d = S_IDLE;
            end
        end

        // clr overrides history and stats even when an update lands on the same edge
        if (clr) begin
            state_d = S_CLEAR;
            ptr_d   = '0;
            ghr_d   = '0;
            lk_d    = '0;
            mp_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            ghr_q   <= '0;
            lk_q    <= '0;
            mp_q    <= '0;
            for (int i = 0; i < N_ENT; i++) begin
                tbl_q[i] <= CNT_INIT;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
            lk_q    <= lk_d;
            mp_q    <= mp_d;
            tbl_q   <= tbl_d;
        end
    end

endmodule

// File: tb/tb_branch_pred_gen.sv
// Scoreboard bench: a gshare and a bimodal instance share stimulus and are checked
// every cycle against an abstract table/history model.
module tb_branch_pred_gen;

    localparam int CNT_INIT_I = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_vld;
    logic [31:0] lookup_pc;
    logic        upd_vld;
    logic [3:0]  upd_idx;
    logic        upd_taken;
    logic        upd_pred;
    logic        clr;

    logic        gs_pred, bm_pred, gs_busy, bm_busy;
    logic [3:0]  gs_idx, bm_idx;
    logic [31:0] gs_lk, gs_mp, bm_lk, bm_mp;

    always #5 clk = ~clk;

    branch_pred_gen #(.PC_W(32), .IDX_W(4), .HIST_W(4), .MODE(2), .CNT_INIT(2'b01)) u_gs (
        .clk(clk), .rst(rst), .lookup_vld(lookup_vld), .lookup_pc(lookup_pc),
        .pred_taken(gs_pred), .pred_idx(gs_idx), .upd_vld(upd_vld), .upd_idx(upd_idx),
        .upd_taken(upd_taken), .upd_pred(upd_pred), .clr(clr), .busy(gs_busy),
        .stat_lookups(gs_lk), .stat_mispred(gs_mp));

    branch_pred_gen #(.PC_W(32), .IDX_W(4), .HIST_W(4), .MODE(1), .CNT_INIT(2'b01)) u_bm (
        .clk(clk), .rst(rst), .lookup_vld(lookup_vld), .lookup_pc(lookup_pc),
        .pred_taken(bm_pred), .pred_idx(bm_idx), .upd_vld(upd_vld), .upd_idx(upd_idx),
        .upd_taken(upd_taken), .upd_pred(upd_pred), .clr(clr), .busy(bm_busy),
        .stat_lookups(bm_lk), .stat_mispred(bm_mp));

    typedef struct {
        logic        gs_pred;
        logic [3:0]  gs_idx;
        logic        bm_pred;
        logic [3:0]  bm_idx;
        logic        busy;
        logic [31:0] lk;
        logic [31:0] mp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    int          m_tbl [16];
    int          m_ghr;
    int unsigned m_lk, m_mp;
    int          m_sweep_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = CNT_INIT_I;
        m_ghr = 0;
        m_lk = 0;
        m_mp = 0;
        m_sweep_left = 0;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic uv,
                         input logic [3:0] ui, input logic ut, input logic up, input logic c);
        exp_t e;
        int   gi, bi;
        logic bsy;
        lookup_vld = v;
        lookup_pc  = pc;
        upd_vld    = uv;
        upd_idx    = ui;
        upd_taken  = ut;
        upd_pred   = up;
        clr        = c;
        bsy = (m_sweep_left > 0);
        gi = (int'(pc[3:0]) ^ m_ghr) & 15;
        bi = int'(pc[3:0]);
        e.gs_idx  = 4'(gi);
        e.bm_idx  = 4'(bi);
        e.gs_pred = (v && !bsy) ? (m_tbl[gi] >= 2) : 1'b0;
        e.bm_pred = (v && !bsy) ? (m_tbl[bi] >= 2) : 1'b0;
        e.busy    = bsy;
        e.lk      = m_lk;
        e.mp      = m_mp;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_sweep_left > 0) begin
            m_tbl[16 - m_sweep_left] = CNT_INIT_I;
            m_sweep_left--;
        end else begin
            if (lookup_vld && m_lk != 32'hFFFF_FFFF) m_lk++;
            if (upd_vld) begin
                if (upd_taken) m_tbl[upd_idx] = (m_tbl[upd_idx] == 3) ? 3 : m_tbl[upd_idx] + 1;
                else           m_tbl[upd_idx] = (m_tbl[upd_idx] == 0) ? 0 : m_tbl[upd_idx] - 1;
                m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 15;
                if (upd_taken != upd_pred && m_mp != 32'hFFFF_FFFF) m_mp++;
            end
        end
        if (clr) begin
            m_sweep_left = 16;
            m_ghr = 0;
            m_lk = 0;
            m_mp = 0;
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("gs_pred_taken", 32'(gs_pred), 32'(e.gs_pred));
            chk("gs_pred_idx",   32'(gs_idx),  32'(e.gs_idx));
            chk("bm_pred_taken", 32'(bm_pred), 32'(e.bm_pred));
            chk("bm_pred_idx",   32'(bm_idx),  32'(e.bm_idx));
            chk("gs_busy",       32'(gs_busy), 32'(e.busy));
            chk("bm_busy",       32'(bm_busy), 32'(e.busy));
            chk("gs_stat_lookups", gs_lk, e.lk);
            chk("gs_stat_mispred", gs_mp, e.mp);
            chk("bm_stat_lookups", bm_lk, e.lk);
            chk("bm_stat_mispred", bm_mp, e.mp);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  nbusy;
        logic t;
        rst = 1'b1;
        lookup_vld = 0; lookup_pc = '0; upd_vld = 0; upd_idx = '0;
        upd_taken = 0; upd_pred = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        drive(1, 32'd5, 0, 0, 0, 0, 0);
        chk("rst_pred_idx", 32'(gs_idx), 32'd5);
        chk("rst_pred_taken", 32'(gs_pred), 32'd0);
        chk("rst_busy", 32'(gs_busy), 32'd0);
        chk("rst_stats", gs_lk | gs_mp, 32'd0);
        tick();

        // bimodal saturation on entry 3
        repeat (3) begin drive(0, 0, 1, 4'd3, 1, 0, 0); tick(); end
        drive(1, 32'd3, 0, 0, 0, 0, 0);
        chk("bm_taken_pred", 32'(bm_pred), 32'd1);
        tick();
        drive(0, 0, 1, 4'd3, 1, 0, 0); tick();
        drive(0, 0, 1, 4'd3, 0, 0, 0); tick();
        drive(1, 32'd3, 0, 0, 0, 0, 0);
        chk("bm_sat_high", 32'(bm_pred), 32'd1);
        tick();
        repeat (3) begin drive(0, 0, 1, 4'd3, 0, 0, 0); tick(); end
        drive(1, 32'd3, 0, 0, 0, 0, 0);
        chk("bm_sat_low", 32'(bm_pred), 32'd0);
        tick();

        // gshare history T,T,N,T
        drive(0, 0, 1, 4'd9, 1, 1, 0); tick();
        drive(0, 0, 1, 4'd9, 1, 1, 0); tick();
        drive(0, 0, 1, 4'd9, 0, 0, 0); tick();
        drive(0, 0, 1, 4'd9, 1, 1, 0); tick();
        drive(1, 32'h0000_0006, 0, 0, 0, 0, 0);
        chk("gshare_idx", 32'(gs_idx), 32'hB);
        tick();

        // clear sweep
        for (int e = 0; e < 4; e++) begin
            repeat (3) begin drive(0, 0, 1, 4'(e), 1, 1, 0); tick(); end
        end
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        nbusy = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'(i), 1, 4'(i), 1, 0, 0);
            if (gs_busy) nbusy++;
            tick();
        end
        chk("clr_busy_len", 32'(nbusy), 32'd16);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("clr_busy_end", 32'(gs_busy), 32'd0);
        chk("clr_stat_lookups", gs_lk, 32'd0);
        chk("clr_stat_mispred", gs_mp, 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'(i), 0, 0, 0, 0, 0);
            tick();
        end

        // mispredict / lookup statistics
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        repeat (16) idle();
        for (int k = 0; k < 10; k++) begin
            t = 1'($urandom_range(0, 1));
            drive(k < 7, $urandom, 1, 4'($urandom_range(0, 15)), t, (k < 3) ? ~t : t, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("stat_mispred_3", gs_mp, 32'd3);
        chk("stat_lookups_7", bm_lk, 32'd7);
        tick();

        // reset in the middle of a sweep
        repeat (3) begin drive(0, 0, 1, 4'd12, 1, 1, 0); tick(); end
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        repeat (8) idle();
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(gs_busy | bm_busy), 32'd0);
        model_reset();
        #1 rst = 1'b0;
        drive(1, 32'd12, 0, 0, 0, 0, 0);
        chk("rst_mid_entry12", 32'(bm_pred), 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'(i), 0, 0, 0, 0, 0);
            tick();
        end

        // same-cycle update/lookup hazard on entry 2
        drive(1, 32'd2, 1, 4'd2, 1, 1, 0);
        chk("hazard_old", 32'(bm_pred), 32'd0);
        tick();
        drive(1, 32'd2, 0, 0, 0, 0, 0);
        chk("hazard_new", 32'(bm_pred), 32'd1);
        tick();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
            tick();
        end

        chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
